// File: rtl/bt_cmd_decoder.sv
// rtl/bt_cmd_decoder.sv - HC-05 byte stream to held direction and toggle pulses.
// BT_CMD_HOLD_TIMEOUT_EN enables the HOLD_CYCLES direction watchdog.
module bt_cmd_decoder #(
  parameter int HOLD_CYCLES  = 10_000_000,
  parameter int REARM_CYCLES = 30_000_000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_valid,
  output logic [2:0] o_dir_cmd,
  output logic       o_dir_valid,
  output logic       o_tog_enable,
  output logic       o_tog_speed,
  output logic       o_tog_mode,
  output logic       o_tog_fan,
  output logic [7:0] o_last_byte,
  output logic [7:0] o_err_cnt
);

  localparam logic [2:0] DIR_BACK    = 3'b000;
  localparam logic [2:0] DIR_LEFT    = 3'b001;
  localparam logic [2:0] DIR_RIGHT   = 3'b010;
  localparam logic [2:0] DIR_FORWARD = 3'b011;
  localparam logic [2:0] DIR_STOP    = 3'b100;

  localparam int REARM_W = (REARM_CYCLES > 1) ? $clog2(REARM_CYCLES) : 1;

  typedef enum logic {
    S_IDLE,
    S_HOLD
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [2:0]   r_dir_cmd;
  logic [2:0]   w_dir_cmd_nxt;
  logic         r_dir_valid;
  logic         w_dir_valid_nxt;

  logic         w_is_dir;
  logic         w_is_rel;
  logic         w_is_tog;
  logic         w_is_err;
  logic [2:0]   w_dir_code;
  logic [1:0]   w_tog_idx;

  logic         r_locked;
  logic [1:0]   r_lock_code;
  logic [REARM_W-1:0] r_rearm_cnt;
  logic         w_lock_live;
  logic         w_fire;
  logic [3:0]   r_tog;
  logic [7:0]   r_last_byte;
  logic [7:0]   r_err_cnt;

  // Byte classification; toggle index 0..3 = enable, speed, mode, fan.
  always_comb begin
    w_is_dir   = 1'b0;
    w_is_rel   = 1'b0;
    w_is_tog   = 1'b0;
    w_is_err   = 1'b0;
    w_dir_code = DIR_STOP;
    w_tog_idx  = 2'd0;
    if (i_rx_valid) begin
      case (i_rx_data)
        8'hC0: begin w_is_dir = 1'b1; w_dir_code = DIR_FORWARD; end
        8'hE0: begin w_is_dir = 1'b1; w_dir_code = DIR_BACK;    end
        8'hF0: begin w_is_dir = 1'b1; w_dir_code = DIR_LEFT;    end
        8'hF8: begin w_is_dir = 1'b1; w_dir_code = DIR_RIGHT;   end
        8'h00: w_is_rel = 1'b1;
        8'hA8: begin w_is_tog = 1'b1; w_tog_idx = 2'd0; end
        8'h86: begin w_is_tog = 1'b1; w_tog_idx = 2'd1; end
        8'hB0: begin w_is_tog = 1'b1; w_tog_idx = 2'd2; end
        8'hA6: begin w_is_tog = 1'b1; w_tog_idx = 2'd3; end
        default: w_is_err = 1'b1;
      endcase
    end
  end

`ifdef BT_CMD_HOLD_TIMEOUT_EN
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [HOLD_W-1:0] w_hold_cnt_nxt;
`endif

  always_comb begin
    w_state_nxt     = r_state;
    w_dir_cmd_nxt   = r_dir_cmd;
    w_dir_valid_nxt = r_dir_valid;
`ifdef BT_CMD_HOLD_TIMEOUT_EN
    w_hold_cnt_nxt  = r_hold_cnt;
`endif
    if (w_is_dir) begin
      w_state_nxt     = S_HOLD;
      w_dir_cmd_nxt   = w_dir_code;
      w_dir_valid_nxt = 1'b1;
`ifdef BT_CMD_HOLD_TIMEOUT_EN
      w_hold_cnt_nxt  = HOLD_W'(HOLD_CYCLES - 1);
`endif
    end else if (r_state == S_HOLD) begin
      if (w_is_rel) begin
        w_state_nxt     = S_IDLE;
        w_dir_cmd_nxt   = DIR_STOP;
        w_dir_valid_nxt = 1'b0;
`ifdef BT_CMD_HOLD_TIMEOUT_EN
        w_hold_cnt_nxt  = '0;
      end else if (r_hold_cnt == '0) begin
        w_state_nxt     = S_IDLE;
        w_dir_cmd_nxt   = DIR_STOP;
        w_dir_valid_nxt = 1'b0;
      end else begin
        w_hold_cnt_nxt  = r_hold_cnt - 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_dir_cmd   <= DIR_STOP;
      r_dir_valid <= 1'b0;
`ifdef BT_CMD_HOLD_TIMEOUT_EN
      r_hold_cnt  <= '0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_dir_cmd   <= w_dir_cmd_nxt;
      r_dir_valid <= w_dir_valid_nxt;
`ifdef BT_CMD_HOLD_TIMEOUT_EN
      r_hold_cnt  <= w_hold_cnt_nxt;
`endif
    end
  end

  // An expired rearm counter counts as unlocked in the same cycle, so expiry wins over a repeat.
  assign w_lock_live = r_locked && (r_rearm_cnt != '0);
  assign w_fire      = w_is_tog && (!w_lock_live || (r_lock_code != w_tog_idx));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_locked    <= 1'b0;
      r_lock_code <= 2'd0;
      r_rearm_cnt <= '0;
      r_tog       <= 4'b0000;
    end else begin
      r_tog <= w_fire ? (4'b0001 << w_tog_idx) : 4'b0000;
      if (w_is_tog) begin
        r_locked    <= 1'b1;
        r_lock_code <= w_tog_idx;
        r_rearm_cnt <= REARM_W'(REARM_CYCLES - 1);
      end else begin
        if (w_is_dir || w_is_rel || (r_rearm_cnt == '0)) begin
          r_locked <= 1'b0;
        end
        if (r_rearm_cnt != '0) begin
          r_rearm_cnt <= r_rearm_cnt - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last_byte <= 8'h00;
      r_err_cnt   <= 8'h00;
    end else begin
      if (i_rx_valid) begin
        r_last_byte <= i_rx_data;
      end
      if (w_is_err && (r_err_cnt != 8'hFF)) begin
        r_err_cnt <= r_err_cnt + 8'h01;
      end
    end
  end

  assign o_dir_cmd    = r_dir_cmd;
  assign o_dir_valid  = r_dir_valid;
  assign o_tog_enable = r_tog[0];
  assign o_tog_speed  = r_tog[1];
  assign o_tog_mode   = r_tog[2];
  assign o_tog_fan    = r_tog[3];
  assign o_last_byte  = r_last_byte;
  assign o_err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_bt_cmd_decoder.sv
// tb/tb_bt_cmd_decoder.sv - directed bench for bt_cmd_decoder (HOLD_CYCLES=20, REARM_CYCLES=50).
module tb_bt_cmd_decoder;

  logic       clk;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [2:0] dir_cmd;
  logic       dir_valid;
  logic       tog_enable;
  logic       tog_speed;
  logic       tog_mode;
  logic       tog_fan;
  logic [7:0] last_byte;
  logic [7:0] err_cnt;

  int n_total = 0;
  int n_bad   = 0;
  int pulses;
  int first_pulse;

  bt_cmd_decoder #(
    .HOLD_CYCLES  (20),
    .REARM_CYCLES (50)
  ) u_dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_rx_data    (rx_data),
    .i_rx_valid   (rx_valid),
    .o_dir_cmd    (dir_cmd),
    .o_dir_valid  (dir_valid),
    .o_tog_enable (tog_enable),
    .o_tog_speed  (tog_speed),
    .o_tog_mode   (tog_mode),
    .o_tog_fan    (tog_fan),
    .o_last_byte  (last_byte),
    .o_err_cnt    (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    do_reset();

    check("rst_dir",   {29'd0, dir_cmd}, 32'd4);
    check("rst_dval",  {31'd0, dir_valid}, 32'd0);
    check("rst_togs",  {28'd0, tog_fan, tog_mode, tog_speed, tog_enable}, 32'd0);
    check("rst_last",  {24'd0, last_byte}, 32'd0);
    check("rst_err",   {24'd0, err_cnt}, 32'd0);

    // Hold: 0xC0 at cycle 0.
    strobe(8'hC0);
    check("fwd_c1",    {29'd0, dir_cmd}, 32'd3);
    check("fwd_dv_c1", {31'd0, dir_valid}, 32'd1);
    tick(19);
    check("fwd_c20",   {29'd0, dir_cmd}, 32'd3);
    tick(1);
`ifdef BT_CMD_HOLD_TIMEOUT_EN
    check("exp_c21",    {29'd0, dir_cmd}, 32'd4);
    check("exp_dv_c21", {31'd0, dir_valid}, 32'd0);
    tick(79);
    check("exp_c100",   {29'd0, dir_cmd}, 32'd4);
`else
    check("hold_c21",    {29'd0, dir_cmd}, 32'd3);
    check("hold_dv_c21", {31'd0, dir_valid}, 32'd1);
    tick(79);
    check("hold_c100",   {29'd0, dir_cmd}, 32'd3);
`endif

    // Direction byte on the expiry cycle wins.
    do_reset();
    strobe(8'hC0);
    tick(19);
    strobe(8'hF8);
    check("expbyte_dir", {29'd0, dir_cmd}, 32'd2);
    check("expbyte_dv",  {31'd0, dir_valid}, 32'd1);

    // Direction change then release.
    do_reset();
    strobe(8'hC0);
    tick(9);
    check("seq_c10", {29'd0, dir_cmd}, 32'd3);
    strobe(8'hF0);
    check("seq_c11", {29'd0, dir_cmd}, 32'd1);
    tick(4);
    strobe(8'h00);
    check("seq_c16",    {29'd0, dir_cmd}, 32'd4);
    check("seq_dv_c16", {31'd0, dir_valid}, 32'd0);

    // 0xA8 every 10 cycles, five times, then again at cycle 100.
    do_reset();
    pulses      = 0;
    first_pulse = -1;
    for (int c = 0; c < 100; c++) begin
      if ((c % 10 == 0) && (c < 50)) begin
        strobe(8'hA8);
      end else begin
        tick(1);
      end
      if (tog_enable) begin
        pulses++;
        if (first_pulse < 0) first_pulse = c + 1;
      end
    end
    check("rep_pulses", pulses, 32'd1);
    check("rep_first",  first_pulse, 32'd1);
    strobe(8'hA8);
    check("rep_c101",   {31'd0, tog_enable}, 32'd1);
    tick(1);
    check("rep_c102",   {31'd0, tog_enable}, 32'd0);

    // Repeat one cycle before expiry is swallowed; repeat on the expiry cycle fires.
    do_reset();
    strobe(8'hA8);
    check("rearm_c1",  {31'd0, tog_enable}, 32'd1);
    tick(48);
    strobe(8'hA8);
    check("rearm_c50", {31'd0, tog_enable}, 32'd0);
    tick(49);
    strobe(8'hA8);
    check("rearm_c100", {31'd0, tog_enable}, 32'd1);

    // Different codes, lock moves.
    do_reset();
    strobe(8'h86);
    check("spd_c1",  {28'd0, tog_fan, tog_mode, tog_speed, tog_enable}, 32'h2);
    strobe(8'hB0);
    check("mode_c2", {28'd0, tog_fan, tog_mode, tog_speed, tog_enable}, 32'h4);
    tick(3);
    strobe(8'h86);
    check("spd_c6",  {28'd0, tog_fan, tog_mode, tog_speed, tog_enable}, 32'h2);
    strobe(8'hA6);
    check("fan_1",   {31'd0, tog_fan}, 32'd1);
    strobe(8'hA6);
    check("fan_lock", {31'd0, tog_fan}, 32'd0);
    strobe(8'hC0);
    strobe(8'hA6);
    check("fan_unlock_dir", {31'd0, tog_fan}, 32'd1);

    // Unrecognised bytes, back to back.
    do_reset();
    for (int i = 0; i < 3; i++) strobe(8'h55);
    check("err_3", {24'd0, err_cnt}, 32'd3);
    for (int i = 0; i < 297; i++) strobe(8'h55);
    check("err_sat",  {24'd0, err_cnt}, 32'd255);
    check("err_last", {24'd0, last_byte}, 32'h55);
    check("err_dir",  {29'd0, dir_cmd}, 32'd4);
    check("err_togs", {28'd0, tog_fan, tog_mode, tog_speed, tog_enable}, 32'd0);

    // Reset mid-HOLD and mid-lock, with a toggle byte presented during reset.
    do_reset();
    strobe(8'hE0);
    check("back_c1", {29'd0, dir_cmd}, 32'd0);
    strobe(8'hA8);
    tick(3);
    rst      = 1'b1;
    rx_data  = 8'hA6;
    rx_valid = 1'b1;
    tick(1);
    rst      = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    check("mrst_dir",  {29'd0, dir_cmd}, 32'd4);
    check("mrst_dv",   {31'd0, dir_valid}, 32'd0);
    check("mrst_togs", {28'd0, tog_fan, tog_mode, tog_speed, tog_enable}, 32'd0);
    check("mrst_last", {24'd0, last_byte}, 32'd0);
    check("mrst_err",  {24'd0, err_cnt}, 32'd0);
    strobe(8'hA8);
    check("mrst_en",   {31'd0, tog_enable}, 32'd1);
    check("mrst_last2", {24'd0, last_byte}, 32'hA8);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/bt_cmd_decoder.md
# bt_cmd_decoder

Decodes the byte stream from the HC-05 UART receiver into sweeper commands: held motion directions and single-cycle toggle pulses for enable, speed, mode and fan. It sits between `uart_rx` and the sweeper top-level control. The phone app repeats a byte while a button is held, so this block converts those repeats into clean level and edge semantics. It replaces raw byte compares in the top level with registered, timeout-guarded outputs.

## Interface
- `HOLD_CYCLES`, default 10_000_000: idle cycles after the last direction byte before the direction falls back to STOP (100 ms at 100 MHz).
- `REARM_CYCLES`, default 30_000_000: idle cycles after the last receipt of a toggle byte before that same byte may pulse again.
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  reset, synchronous, active-high.
- `rx_data`  in  8  byte from `uart_rx`; valid only while `rx_valid` is high.
- `rx_valid`  in  1  one-cycle strobe marking a new byte.
- `dir_cmd`  out  3  motion code: BACK 000, LEFT 001, RIGHT 010, FORWARD 011, STOP 100.
- `dir_valid`  out  1  high while a non-STOP direction is held.
- `tog_enable`, `tog_speed`, `tog_mode`, `tog_fan`  out  1 each  single-cycle toggle pulses.
- `last_byte`  out  8  last received byte of any kind, for the seven-segment debug display.
- `err_cnt`  out  8  saturating count of unrecognised bytes.

## Operation
- Byte map:
  - Directions: 0xC0 FORWARD, 0xE0 BACK, 0xF0 LEFT, 0xF8 RIGHT.
  - Release: 0x00.
  - Toggles: 0xA8 enable, 0x86 speed, 0xB0 mode, 0xA6 fan.
  - Any other value is unrecognised.
- Direction FSM, states IDLE and HOLD:
  - A direction byte in any state: go to HOLD, load `dir_cmd`, set `dir_valid`, reload the hold counter to HOLD_CYCLES-1.
  - In HOLD the counter decrements once per cycle. At 0 with no new byte: go to IDLE, `dir_cmd`=STOP, `dir_valid`=0.
  - 0x00 in HOLD: go to IDLE immediately.
  - Toggle or unrecognised bytes do not affect the direction FSM or the hold counter.
- Toggle lock: a register holds the last toggle code plus a lock flag, and a rearm counter runs alongside it.
  - Toggle byte when unlocked, or when it differs from the locked code: pulse the matching `tog_*` output, lock on that code, load the rearm counter to REARM_CYCLES-1.
  - Same code while locked: no pulse; reload the rearm counter.
  - Rearm counter reaching 0: clear the lock.
  - A direction byte or 0x00 also clears the lock.
- Unrecognised byte: `err_cnt` increments and saturates at 255. No other effect.
- `last_byte` updates on every `rx_valid`.
- Counter widths: `$clog2(param)` bits. The counters must never wrap: each holds at 0 until reloaded.

## Timing
- Every output is registered. A byte strobed at cycle N takes effect at cycle N+1. Each `tog_*` pulse is exactly one cycle wide, at N+1.
- At most one `tog_*` output is high in any cycle.
- Reset values: `dir_cmd`=100, `dir_valid`=0, all `tog_*`=0, `last_byte`=0, `err_cnt`=0, lock clear, both counters 0, FSM in IDLE.
- Boundary conditions:
  - Hold expiry and a direction byte in the same cycle: the byte wins; HOLD continues with the new code and a reloaded counter.
  - Rearm expiry and the same toggle byte in the same cycle: expiry is applied first, so the pulse fires and the lock is re-armed.
  - `rst` asserted mid-HOLD or mid-lock: everything returns to reset values on the next edge. No pulse is emitted during reset.
  - Back-to-back `rx_valid` on consecutive cycles: each byte is processed in full.

## Configuration
- `BT_CMD_HOLD_TIMEOUT_EN` defined: the HOLD_CYCLES watchdog is active as described above.
- Not defined: the hold counter is removed. HOLD is left only by 0x00, a new direction byte, or `rst`. The toggle-lock rearm timeout remains in both builds.

## Test plan
- HOLD_CYCLES=20. Strobe 0xC0 at cycle 0:
  - `dir_cmd`=011 and `dir_valid`=1 from cycle 1.
  - STOP and `dir_valid`=0 at cycle 21.
  - With the macro undefined, still 011 at cycle 100.
- 0xC0, then 0xF0 at cycle 10, then 0x00 at cycle 15:
  - `dir_cmd` reads 011, then 001 at cycle 11, then 100 at cycle 16.
- REARM_CYCLES=50. 0xA8 strobed every 10 cycles, five times:
  - Exactly one `tog_enable` pulse, at cycle 1.
  - Silence until cycle 100, then 0xA8: a second pulse at cycle 101.
- 0x86 followed by 0xB0 on consecutive cycles:
  - `tog_speed` pulses at cycle 1, `tog_mode` at cycle 2.
  - Then 0x86 again at cycle 5 pulses `tog_speed`, because the lock moved to 0xB0.
- 300 strobes of 0x55:
  - `err_cnt` saturates at 255.
  - `last_byte`=0x55.
  - `dir_cmd` stays 100.
- 0xE0, then `rst` at cycle 5:
  - Every output returns to its reset value at cycle 6.
  - A subsequent 0xA8 pulses `tog_enable`.
